inst_queue: RTL and testbench
=============================

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default INST_QUEUE_DEPTH (16), number of buffered fetch packets; power of two, >= 2.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  fetch presents a packet.
REQ-005 SHALL have port in_ready  output  1  queue accepts a packet this cycle.
REQ-006 SHALL have port in_pc  input  32  PC of the incoming instruction.
REQ-007 SHALL have port in_inst  input  32  incoming instruction word.
REQ-008 SHALL have port out_valid  output  1  head packet available to the backend.
REQ-009 SHALL have port out_ready  input  1  backend (id_stage) consumes the head this cycle.
REQ-010 SHALL have port out_pc  output  32  head PC.
REQ-011 SHALL have port out_inst  output  32  head instruction.
REQ-012 SHALL have port flush  input  1  backend_flush; discard all contents.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-014 SHALL store packets in a circular buffer with head/tail pointers of $clog2(DEPTH)+1 bits; empty = pointers equal, full = index bits equal and MSBs differ.
REQ-015 SHALL enqueue when in_valid && in_ready; SHALL dequeue when out_valid && out_ready.
REQ-016 SHALL drive in_ready = !full && !flush, independent of out_ready (no enqueue-into-full even with a simultaneous dequeue).
REQ-017 SHALL drive out_valid = !empty && !flush; out_pc/out_inst SHALL come combinationally from the head entry; values are don't-care while out_valid is low.
REQ-018 SHALL allow enqueue and dequeue in the same cycle; count unchanged, both pointers advance.
REQ-019 SHALL wrap pointers modulo 2*DEPTH, indices modulo DEPTH, with no lost or duplicated entry across the wrap.
REQ-020 SHALL, with flush high, set head = tail = 0 and count = 0 on the next edge, ignoring any handshake presented in that cycle.
REQ-021 SHALL give enqueue-to-out_valid latency of 1 cycle (bypass disabled).
REQ-022 SHALL keep count equal to tail - head at every edge; count updates on the same edge as the pointers.

Reset
REQ-023 SHALL, while rst is high at an edge, set head = tail = 0, count = 0; outputs then in_ready = 1, out_valid = 0.
REQ-024 SHALL give rst priority over flush and all handshakes, including reset asserted mid-stream with a full queue.
REQ-025 SHALL not reset the storage array.

Configuration
REQ-026 SHALL support macro INST_QUEUE_BYPASS_EN; when undefined, behaviour is exactly REQ-014..REQ-022.
REQ-027 SHALL, with INST_QUEUE_BYPASS_EN defined and the queue empty and flush low, drive out_valid = in_valid, out_pc = in_pc, out_inst = in_inst combinationally.
REQ-028 SHALL, in bypass, not write the entry if out_ready is high in that cycle (pointers and count unchanged); otherwise write it normally.

Structure
REQ-029 SHALL take INST_QUEUE_DEPTH and typedef fetch_pkt_t {pc[31:0], inst[31:0]} from package cpu_params.
REQ-030 SHALL place storage in one sub-module inst_queue_mem (DEPTH x fetch_pkt_t, one synchronous write port, one combinational read port).

Verification
REQ-031 SHALL cover: reset, then in_valid=1 pc=0x1eceb000 inst=0x00000013 for 1 cycle, out_ready=0 -> next cycle out_valid=1, out_pc=0x1eceb000, count=1.
REQ-032 SHALL cover: 16 enqueues (pc 0x1000 + 4i), no dequeue -> in_ready=0, count=16; 17th in_valid ignored; draining returns pc 0x1000..0x103c in order.
REQ-033 SHALL cover: queue full, in_valid=1 and out_ready=1 same cycle -> dequeue only, count=15, in_ready=1 next cycle.
REQ-034 SHALL cover: 40 packets streamed with random out_ready stalls -> all 40 delivered in order across two pointer wraps, none lost or duplicated.
REQ-035 SHALL cover: count=7, flush=1 with in_valid=1 and out_ready=1 -> neither handshake takes effect; next cycle count=0, out_valid=0, in_ready=1.
REQ-036 SHALL cover, with INST_QUEUE_BYPASS_EN: empty, in_valid=1 pc=0x2000, out_ready=1 -> out_valid=1, out_pc=0x2000 same cycle; count stays 0.

Source files
------------

// File: rtl/cpu_params.sv
// Shared CPU-wide parameters and the fetch packet type used by the front end.
package cpu_params;

  localparam int INST_QUEUE_DEPTH = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_pkt_t;

endpackage

// File: rtl/inst_queue_mem.sv
// Packet storage for inst_queue: one synchronous write port, one combinational read port.
// Contents are intentionally not reset.
module inst_queue_mem
  import cpu_params::*;
#(
  parameter int DEPTH = INST_QUEUE_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  fetch_pkt_t               wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output fetch_pkt_t               rdata
);

  fetch_pkt_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue (circular buffer, extra pointer MSB for full/empty).
// Optional same-cycle bypass of an empty queue when INST_QUEUE_BYPASS_EN is defined.
module inst_queue
  import cpu_params::*;
#(
  parameter int DEPTH = INST_QUEUE_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] head_reg, head_next;
  logic [PW-1:0] tail_reg, tail_next;
  logic          empty, full;
  logic          enq, deq, wr_en;
  fetch_pkt_t    wr_pkt, head_pkt;

  assign empty = (head_reg == tail_reg);
  assign full  = (head_reg[AW-1:0] == tail_reg[AW-1:0]) && (head_reg[AW] != tail_reg[AW]);

  assign in_ready = !full && !flush;
  assign enq      = in_valid && in_ready;
  assign wr_pkt   = '{pc: in_pc, inst: in_inst};

`ifdef INST_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass    = empty && !flush;
  assign out_valid = bypass ? in_valid : (!empty && !flush);
  assign out_pc    = bypass ? in_pc    : head_pkt.pc;
  assign out_inst  = bypass ? in_inst  : head_pkt.inst;
  // A bypassed packet consumed in the same cycle never touches the storage.
  assign wr_en     = enq && !(bypass && out_ready);
  assign deq       = out_valid && out_ready && !empty;
`else
  assign out_valid = !empty && !flush;
  assign out_pc    = head_pkt.pc;
  assign out_inst  = head_pkt.inst;
  assign wr_en     = enq;
  assign deq       = out_valid && out_ready;
`endif

  always_comb begin
    head_next = head_reg;
    tail_next = tail_reg;
    if (flush) begin
      head_next = '0;
      tail_next = '0;
    end else begin
      if (wr_en) tail_next = tail_reg + 1'b1;
      if (deq)   head_next = head_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg <= '0;
      tail_reg <= '0;
    end else begin
      head_reg <= head_next;
      tail_reg <= tail_next;
    end
  end

  assign count = tail_reg - head_reg;

  inst_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (tail_reg[AW-1:0]),
    .wdata (wr_pkt),
    .raddr (head_reg[AW-1:0]),
    .rdata (head_pkt)
  );

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue (default build and INST_QUEUE_BYPASS_EN build).
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        flush;
  logic [4:0]  count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .flush     (flush),
    .count     (count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_pc    = base + 32'(4 * i);
      in_inst  = 32'h0000_0013 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int s;
    int r;
    int cyc;
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0; flush = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_count", 32'(count), 32'd0);

    // Single enqueue, visible next cycle.
    in_valid = 1'b1; in_pc = 32'h1eceb000; in_inst = 32'h00000013;
    tick();
    in_valid = 1'b0;
    #1;
    chk("single_out_valid", 32'(out_valid), 32'd1);
    chk("single_out_pc", out_pc, 32'h1eceb000);
    chk("single_out_inst", out_inst, 32'h00000013);
    chk("single_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    chk("single_drained", 32'(count), 32'd0);

    // Fill to capacity, overflow attempt, drain in order.
    fill(16, 32'h1000);
    #1;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(count), 32'd16);
    in_valid = 1'b1; in_pc = 32'hdead_beef;
    tick();
    in_valid = 1'b0;
    #1;
    chk("overflow_count", 32'(count), 32'd16);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk($sformatf("drain_valid_%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("drain_pc_%0d", i), out_pc, 32'h1000 + 32'(4 * i));
      $display("drain: pc=0x%08h inst=0x%08h", out_pc, out_inst);
      tick();
    end
    out_ready = 1'b0;
    #1;
    chk("drain_empty_valid", 32'(out_valid), 32'd0);
    chk("drain_empty_count", 32'(count), 32'd0);

    // Full queue with simultaneous push and pop: only the pop happens.
    fill(16, 32'h3000);
    in_valid = 1'b1; in_pc = 32'h4000; out_ready = 1'b1;
    #1;
    chk("fullpp_in_ready", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("fullpp_count", 32'(count), 32'd15);
    chk("fullpp_in_ready_next", 32'(in_ready), 32'd1);
    chk("fullpp_head_pc", out_pc, 32'h3004);

    // Flush with count=7 and both handshakes presented.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("flush1_count", 32'(count), 32'd0);
    fill(7, 32'h6000);
    #1;
    chk("pre_flush_count", 32'(count), 32'd7);
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h7000; out_ready = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_valid_next", 32'(out_valid), 32'd0);
    chk("flush_in_ready_next", 32'(in_ready), 32'd1);

    // Streaming 40 packets with random consumer stalls.
    s = 0; r = 0; cyc = 0;
    while (r < 40 && cyc < 2000) begin
      in_valid  = (s < 40);
      in_pc     = 32'h5000 + 32'(4 * s);
      in_inst   = 32'h0000_0013 + 32'(s);
      out_ready = ($urandom_range(0, 2) == 0);
      #1;
      chk($sformatf("stream_count_c%0d", cyc), 32'(count), 32'(s - r));
      if (out_valid && out_ready) begin
        chk($sformatf("stream_pc_%0d", r), out_pc, 32'h5000 + 32'(4 * r));
        $display("stream: idx=%0d pc=0x%08h", r, out_pc);
        r++;
      end
      if (in_valid && in_ready) s++;
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("stream_received", 32'(r), 32'd40);
    chk("stream_end_count", 32'(count), 32'd0);

    // Reset takes priority over flush and handshakes on a full queue.
    fill(16, 32'h8000);
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);

`ifdef INST_QUEUE_BYPASS_EN
    in_valid = 1'b1; in_pc = 32'h2000; in_inst = 32'h0000_0093; out_ready = 1'b1;
    #1;
    chk("bypass_out_valid", 32'(out_valid), 32'd1);
    chk("bypass_out_pc", out_pc, 32'h2000);
    chk("bypass_out_inst", out_inst, 32'h0000_0093);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("bypass_count", 32'(count), 32'd0);
    chk("bypass_out_valid_after", 32'(out_valid), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
